// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register, IDCODE and
// BYPASS data registers, and decode of enables for one external user data register.
module jtag_tap_controller #(
  parameter int unsigned          IR_WIDTH      = 4,
  parameter logic [31:0]          IDCODE_VALUE  = 32'h1000_563D,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OPCODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]  USER_OPCODE   = IR_WIDTH'(2)
) (
  input  logic                tclk,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  input  logic                dr_tdo,
  output logic                tdo,
  output logic                tdo_en,
  output logic                dr_capture_en,
  output logic                dr_shift_en,
  output logic                dr_update_en,
  output logic                dr_tdi,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    TLR     = 4'hF, RTI     = 4'hC,
    SEL_DR  = 4'h7, CAP_DR  = 4'h6, SH_DR   = 4'h2, EX1_DR  = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR  = 4'h5,
    SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA, EX1_IR  = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR  = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {INSN_BYPASS, INSN_IDCODE, INSN_USER} insn_e;

  // Fixed pattern captured into the IR; the trailing 01 lets a scan verify chain length.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e          r_state;
  tap_state_e          w_next_state;
  insn_e               w_insn;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_ir_value;
  logic [31:0]         r_idcode;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_tdo_en;
  logic                w_dr_out;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) r_state <= TLR;
    else      r_state <= w_next_state;
  end

  // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      TLR:      w_next_state = tms ? TLR    : RTI;
      RTI:      w_next_state = tms ? SEL_DR : RTI;
      SEL_DR:   w_next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR:   w_next_state = tms ? EX1_DR : SH_DR;
      SH_DR:    w_next_state = tms ? EX1_DR : SH_DR;
      EX1_DR:   w_next_state = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: w_next_state = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   w_next_state = tms ? UPD_DR : SH_DR;
      UPD_DR:   w_next_state = tms ? SEL_DR : RTI;
      SEL_IR:   w_next_state = tms ? TLR    : CAP_IR;
      CAP_IR:   w_next_state = tms ? EX1_IR : SH_IR;
      SH_IR:    w_next_state = tms ? EX1_IR : SH_IR;
      EX1_IR:   w_next_state = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: w_next_state = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   w_next_state = tms ? UPD_IR : SH_IR;
      UPD_IR:   w_next_state = tms ? SEL_DR : RTI;
      default:  w_next_state = TLR;
    endcase
  end

  always_comb begin
    w_insn = INSN_BYPASS;
    if (r_ir_value == USER_OPCODE)        w_insn = INSN_USER;
    else if (r_ir_value == IDCODE_OPCODE) w_insn = INSN_IDCODE;
  end

  always_comb begin
    case (w_insn)
      INSN_USER:   w_dr_out = dr_tdo;
      INSN_IDCODE: w_dr_out = r_idcode[0];
      default:     w_dr_out = r_bypass;
    endcase
  end

  // Shift/capture happens on the posedge that leaves Capture/Shift; Pause and Exit hold.
  always_ff @(posedge tclk or posedge trst) begin
    if (trst) begin
      r_ir_shift <= '0;
      r_idcode   <= IDCODE_VALUE;
      r_bypass   <= 1'b0;
    end else begin
      case (r_state)
        CAP_IR: r_ir_shift <= IR_CAPTURE;
        SH_IR:  r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        CAP_DR: begin
          if (w_insn == INSN_IDCODE) r_idcode <= IDCODE_VALUE;
          if (w_insn == INSN_BYPASS) r_bypass <= 1'b0;
        end
        SH_DR: begin
          if (w_insn == INSN_IDCODE) r_idcode <= {tdi, r_idcode[31:1]};
          if (w_insn == INSN_BYPASS) r_bypass <= tdi;
        end
        default: ;
      endcase
    end
  end

  // Falling-edge domain: instruction update and TDO launch, half a cycle after the shift.
  always_ff @(negedge tclk or posedge trst) begin
    if (trst) begin
      r_ir_value <= IDCODE_OPCODE;
      r_tdo      <= 1'b0;
      r_tdo_en   <= 1'b0;
    end else begin
      r_tdo_en <= 1'b0;
      case (r_state)
        UPD_IR: r_ir_value <= r_ir_shift;
        TLR:    r_ir_value <= IDCODE_OPCODE;
        SH_IR: begin
          r_tdo    <= r_ir_shift[0];
          r_tdo_en <= 1'b1;
        end
        SH_DR: begin
          r_tdo    <= w_dr_out;
          r_tdo_en <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dr_capture_en = (r_state == CAP_DR) && (w_insn == INSN_USER);
  assign dr_shift_en   = (r_state == SH_DR)  && (w_insn == INSN_USER);
  assign dr_update_en  = (r_state == UPD_DR) && (w_insn == INSN_USER);
  assign dr_tdi        = tdi;
  assign tdo           = r_tdo;
  assign tdo_en        = r_tdo_en;
  assign ir_value      = r_ir_value;
  assign tap_state     = r_state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: table-driven TAP reference model compared every half
// cycle, scripted scans with literal expectations, then randomized TMS/TDI traffic.
module tb_jtag_tap_controller;

  localparam logic [31:0] IDCODE    = 32'h1000_563D;
  localparam logic [3:0]  OP_IDCODE = 4'h1;
  localparam logic [3:0]  OP_USER   = 4'h2;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
                         S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0,
                         S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
                         S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

  logic       tclk = 1'b0;
  logic       trst = 1'b0;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       dr_tdo = 1'b0;
  logic       tdo, tdo_en, dr_capture_en, dr_shift_en, dr_update_en, dr_tdi;
  logic [3:0] ir_value;
  logic [3:0] tap_state;

  jtag_tap_controller dut (
    .tclk(tclk), .trst(trst), .tms(tms), .tdi(tdi), .dr_tdo(dr_tdo),
    .tdo(tdo), .tdo_en(tdo_en), .dr_capture_en(dr_capture_en),
    .dr_shift_en(dr_shift_en), .dr_update_en(dr_update_en), .dr_tdi(dr_tdi),
    .ir_value(ir_value), .tap_state(tap_state)
  );

  always #5 tclk = ~tclk;

  int n_cmp = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  // Reference model state
  logic [3:0]  m_state, m_ir_sh, m_ir;
  logic [31:0] m_id;
  logic        m_by, m_tdo, m_tdo_en;
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void link(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endfunction

  function automatic void init_tables();
    link(S_TLR, S_RTI, S_TLR);          link(S_RTI, S_RTI, S_SELDR);
    link(S_SELDR, S_CAPDR, S_SELIR);    link(S_CAPDR, S_SHDR, S_EX1DR);
    link(S_SHDR, S_SHDR, S_EX1DR);      link(S_EX1DR, S_PAUSEDR, S_UPDDR);
    link(S_PAUSEDR, S_PAUSEDR, S_EX2DR); link(S_EX2DR, S_SHDR, S_UPDDR);
    link(S_UPDDR, S_RTI, S_SELDR);      link(S_SELIR, S_CAPIR, S_TLR);
    link(S_CAPIR, S_SHIR, S_EX1IR);     link(S_SHIR, S_SHIR, S_EX1IR);
    link(S_EX1IR, S_PAUSEIR, S_UPDIR);  link(S_PAUSEIR, S_PAUSEIR, S_EX2IR);
    link(S_EX2IR, S_SHIR, S_UPDIR);     link(S_UPDIR, S_RTI, S_SELDR);
  endfunction

  // 0 = BYPASS, 1 = IDCODE, 2 = USER
  function automatic int insn_of(input logic [3:0] ir);
    if (ir == OP_USER)   return 2;
    if (ir == OP_IDCODE) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_state = S_TLR; m_ir = OP_IDCODE; m_ir_sh = 4'h0;
    m_id = IDCODE; m_by = 1'b0; m_tdo = 1'b0; m_tdo_en = 1'b0;
  endfunction

  function automatic void model_pos();
    int k = insn_of(m_ir);
    if (m_state == S_CAPIR)      m_ir_sh = 4'b0001;
    else if (m_state == S_SHIR)  m_ir_sh = (m_ir_sh >> 1) | ({3'b000, tdi} << 3);
    else if (m_state == S_CAPDR) begin
      if (k == 1) m_id = IDCODE;
      if (k == 0) m_by = 1'b0;
    end else if (m_state == S_SHDR) begin
      if (k == 1) m_id = (m_id >> 1) | ({31'b0, tdi} << 31);
      if (k == 0) m_by = tdi;
    end
    m_state = tms ? nxt1[m_state] : nxt0[m_state];
  endfunction

  function automatic void model_neg();
    int k = insn_of(m_ir);
    m_tdo_en = 1'b0;
    if (m_state == S_UPDIR) m_ir = m_ir_sh;
    if (m_state == S_TLR)   m_ir = OP_IDCODE;
    if (m_state == S_SHIR) begin
      m_tdo = m_ir_sh[0]; m_tdo_en = 1'b1;
    end
    if (m_state == S_SHDR) begin
      m_tdo = (k == 2) ? dr_tdo : (k == 1) ? m_id[0] : m_by;
      m_tdo_en = 1'b1;
    end
  endfunction

  // Compare process: combinational decodes after posedge, falling-edge outputs after negedge.
  always begin
    @(posedge tclk); #2;
    if (run_cmp) begin
      check("state",   32'(tap_state),     32'(m_state));
      check("cap_en",  32'(dr_capture_en), 32'(m_state == S_CAPDR && insn_of(m_ir) == 2));
      check("shift_en", 32'(dr_shift_en),  32'(m_state == S_SHDR && insn_of(m_ir) == 2));
      check("upd_en",  32'(dr_update_en),  32'(m_state == S_UPDDR && insn_of(m_ir) == 2));
      check("dr_tdi",  32'(dr_tdi),        32'(tdi));
    end
    @(negedge tclk); #2;
    if (run_cmp) begin
      check("tdo",      32'(tdo),      32'(m_tdo));
      check("tdo_en",   32'(tdo_en),   32'(m_tdo_en));
      check("ir_value", 32'(ir_value), 32'(m_ir));
    end
  end

  // Called between a negedge and the next posedge; returns just after the following negedge.
  task automatic step(input logic t_ms, input logic t_di, input logic t_do);
    tms = t_ms; tdi = t_di; dr_tdo = t_do;
    @(posedge tclk); model_pos();
    @(negedge tclk); model_neg();
    #1;
  endtask

  task automatic do_reset();
    trst = 1'b1;
    model_reset();
    #1;
    check("rst_state",  32'(tap_state), 32'(S_TLR));
    check("rst_ir",     32'(ir_value),  32'(OP_IDCODE));
    check("rst_tdo_en", 32'(tdo_en),    32'h0);
    check("rst_tdo",    32'(tdo),       32'h0);
    check("rst_dr_en",  32'({dr_capture_en, dr_shift_en, dr_update_en}), 32'h0);
    @(negedge tclk); #1;
    trst = 1'b0;
  endtask

  // From RTI: scan a 4-bit instruction LSB first and return to RTI.
  task automatic load_ir(input logic [3:0] val);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, val[i], 1'b0);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] got;
    logic [3:0]  irout, bv, tseq;
    int cap_cnt, sh_cnt, upd_cnt, en_seen;
    logic d;

    init_tables();
    model_reset();
    #1;
    run_cmp = 1'b1;
    do_reset();

    // IDCODE scan from TLR: 0,1,0,0 to ShDR then 32 bits LSB first
    step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    got = '0;
    got[0] = tdo;
    check("idcode_first_bit", 32'(tdo), 32'h1);
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'($urandom), 1'b0);
      got[i] = tdo;
      check("idcode_tdo_en", 32'(tdo_en), 32'h1);
    end
    step(1'b1, 1'b0, 1'b0);
    check("idcode_tdo_en_off", 32'(tdo_en), 32'h0);
    check("idcode_word", got, IDCODE);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);

    // IR load to USER, observing the captured 0001 on tdo
    step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    irout = '0;
    irout[0] = tdo;
    tseq = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, tseq[i], 1'b0);
      if (i < 3) irout[i+1] = tdo;
    end
    check("ir_capture_out", 32'(irout), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    check("ir_update_user", 32'(ir_value), 32'h2);
    step(1'b0, 1'b0, 1'b0);

    // USER scan, 8 shift cycles
    cap_cnt = 0; sh_cnt = 0; upd_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      d = 1'($urandom);
      step((i == 0) || (i == 10) || (i == 11), 1'($urandom), d);
      cap_cnt += int'(dr_capture_en);
      sh_cnt  += int'(dr_shift_en);
      upd_cnt += int'(dr_update_en);
      if (tap_state == S_SHDR) check("user_tdo", 32'(tdo), 32'(d));
    end
    check("user_cap_cycles",   32'(cap_cnt), 32'd1);
    check("user_shift_cycles", 32'(sh_cnt),  32'd8);
    check("user_upd_cycles",   32'(upd_cnt), 32'd1);

    // BYPASS with all-ones instruction
    load_ir(4'hF);
    check("ir_bypass", 32'(ir_value), 32'hF);
    en_seen = 0;
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    bv = '0;
    bv[0] = tdo;
    tseq = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, tseq[i], 1'b1);
      en_seen += int'(dr_capture_en | dr_shift_en | dr_update_en);
      if (i < 3) bv[i+1] = tdo;
    end
    check("bypass_tdo", 32'(bv), 32'hA);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    check("bypass_dr_en", 32'(en_seen), 32'd0);

    // Back to IDCODE via five tms=1, then an IDCODE scan interrupted by a 3-cycle PauseDR
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    check("tlr_ir_idcode", 32'(ir_value), 32'h1);
    step(1'b0, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    got = '0;
    got[0] = tdo;
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      got[i] = tdo;
    end
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom), 1'b0);
    check("pause_state", 32'(tap_state), 32'(S_PAUSEDR));
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    got[4] = tdo;
    for (int i = 5; i < 32; i++) begin
      step(1'b0, 1'b0, 1'b0);
      got[i] = tdo;
    end
    check("pause_idcode_word", got, IDCODE);
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);

    // From ShIR, five tms=1 edges reach TLR; UpdIR passes through on the way
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    check("escape_updir_ir", 32'(ir_value), 32'h8);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("escape_state", 32'(tap_state), 32'(S_TLR));
    check("escape_ir",    32'(ir_value),  32'h1);

    // Asynchronous reset in the middle of a USER ShDR
    step(1'b0, 1'b0, 1'b0);
    load_ir(OP_USER);
    step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("pre_rst_shift_en", 32'(dr_shift_en), 32'h1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom));
    end

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
